// File: rtl/stopwatch_core_if.sv
// Command/status bundle for stopwatch_core: single-cycle command pulses in,
// packed BCD count, lap value and status flags out.
interface stopwatch_core_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    start;
    logic                    pause;
    logic                    clear;
    logic                    lap;
    logic                    count_down;
    logic [4*NUM_DIGITS-1:0] preset;
    logic [4*NUM_DIGITS-1:0] bcd_num;
    logic [4*NUM_DIGITS-1:0] lap_num;
    logic                    running;
    logic                    done;
    logic                    overflow;
    logic [1:0]              state;

    modport master (
        output start, pause, clear, lap, count_down, preset,
        input  bcd_num, lap_num, running, done, overflow, state
    );

    modport slave (
        input  start, pause, clear, lap, count_down, preset,
        output bcd_num, lap_num, running, done, overflow, state
    );
endinterface

// File: rtl/stopwatch_core.sv
// Stopwatch/timer datapath: tick divider, control FSM and NUM_DIGITS BCD counter.
// Optional lap register enabled by defining LAP_CAPTURE_EN.
module stopwatch_core #(
    parameter int TICK_DIV   = 100000,
    parameter int NUM_DIGITS = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    stopwatch_core_if.slave   bus
);
    localparam int DIV_W = $clog2(TICK_DIV);
    localparam int W     = 4 * NUM_DIGITS;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        PAUSED = 2'b10,
        DONE   = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [W-1:0]     count_q, count_d, up_val, down_val;
    logic             done_q, done_d, ovf_q, ovf_d, mode_q, mode_d;
    logic             step, up_wrap, carry, borrow;
    logic [3:0]       dig;

    assign step = (state_q == RUN) && (div_q == DIV_LAST);

    // Full ripple of both directions in one cycle; out-of-range digits act as 9.
    always_comb begin
        up_val   = count_q;
        down_val = count_q;
        carry    = 1'b1;
        borrow   = 1'b1;
        dig      = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            dig = count_q[4*i +: 4];
            if (carry) begin
                if (dig >= 4'd9) begin
                    up_val[4*i +: 4] = '0;
                end else begin
                    up_val[4*i +: 4] = dig + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (dig == 4'd0) begin
                    down_val[4*i +: 4] = 4'd9;
                end else begin
                    down_val[4*i +: 4] = (dig > 4'd9) ? 4'd8 : dig - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
        up_wrap = carry;
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        count_d = count_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        mode_d  = mode_q;
        if (bus.clear) begin
            state_d = IDLE;
            div_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    mode_d = bus.count_down;
                    div_d  = '0;
                    if (bus.count_down) begin
                        count_d = bus.preset;
                        if (bus.preset == '0) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        count_d = '0;
                        state_d = RUN;
                    end
                end
                RUN: if (bus.pause) begin
                    state_d = PAUSED;
                end else if (step) begin
                    div_d = '0;
                    if (mode_q) begin
                        count_d = down_val;
                        if (down_val == '0) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        count_d = up_val;
                        if (up_wrap) ovf_d = 1'b1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
                PAUSED: if (bus.start) state_d = RUN;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            count_q <= count_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            mode_q  <= mode_d;
        end
    end

`ifdef LAP_CAPTURE_EN
    logic [W-1:0] lap_q;
    logic         lap_take;

    // Captures count_q, i.e. the pre-step value when a step lands in the same cycle.
    assign lap_take = bus.lap && !bus.clear &&
                      ((state_q == RUN && !bus.pause) || (state_q == PAUSED && !bus.start));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)        lap_q <= '0;
        else if (lap_take) lap_q <= count_q;
    end

    assign bus.lap_num = lap_q;
`else
    assign bus.lap_num = '0;
`endif

    assign bus.bcd_num  = count_q;
    assign bus.running  = (state_q == RUN);
    assign bus.done     = done_q;
    assign bus.overflow = ovf_q;
    assign bus.state    = state_q;
endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: two instances (TICK_DIV=4/2 digits, TICK_DIV=2/4 digits)
// driven in lockstep and compared every cycle against a decimal-arithmetic model.
module tb_stopwatch_core;
`ifdef LAP_CAPTURE_EN
    localparam bit LAP_ON = 1'b1;
`else
    localparam bit LAP_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    stopwatch_core_if #(.NUM_DIGITS(2)) ia ();
    stopwatch_core_if #(.NUM_DIGITS(4)) ib ();

    stopwatch_core #(.TICK_DIV(4), .NUM_DIGITS(2)) u_a (.clk(clk), .n_rst(n_rst), .bus(ia));
    stopwatch_core #(.TICK_DIV(2), .NUM_DIGITS(4)) u_b (.clk(clk), .n_rst(n_rst), .bus(ib));

    typedef struct packed {
        logic [1:0] st;
        int         div;
        int         val;
        int         lap;
        logic       done;
        logic       ovf;
        logic       mode;
    } model_t;

    model_t ma, mb;
    int     vectors = 0;
    int     miscompares = 0;
    int     pre_a, pre_b;
    logic   cd;

    function automatic int pow10(int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [31:0] to_bcd(int v, int nd);
        logic [31:0] r = '0;
        int x = v;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // State codes: 0 idle, 1 run, 2 paused, 3 done. Commands ignored in a state act as absent.
    function automatic model_t m_next(model_t m, int td, int nd, int pre,
                                      logic s, logic p, logic c, logic l, logic d);
        model_t n = m;
        n.done = 1'b0;
        if (c) begin
            n.st = 2'd0; n.val = 0; n.div = 0; n.ovf = 1'b0;
            return n;
        end
        case (m.st)
            2'd0: if (s) begin
                n.mode = d;
                n.div  = 0;
                n.val  = d ? pre : 0;
                if (d && pre == 0) begin n.st = 2'd3; n.done = 1'b1; end
                else n.st = 2'd1;
            end
            2'd1: if (p) n.st = 2'd2;
            else begin
                if (l && LAP_ON) n.lap = m.val;
                if (m.div == td - 1) begin
                    n.div = 0;
                    if (m.mode) begin
                        n.val = m.val - 1;
                        if (n.val == 0) begin n.st = 2'd3; n.done = 1'b1; end
                    end else if (m.val == pow10(nd) - 1) begin
                        n.val = 0; n.ovf = 1'b1;
                    end else begin
                        n.val = m.val + 1;
                    end
                end else begin
                    n.div = m.div + 1;
                end
            end
            2'd2: if (s) n.st = 2'd1;
                  else if (l && LAP_ON) n.lap = m.val;
            default: ;
        endcase
        return n;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_models();
        check("a_bcd",   32'(ia.bcd_num), to_bcd(ma.val, 2));
        check("a_lap",   32'(ia.lap_num), to_bcd(ma.lap, 2));
        check("a_state", 32'(ia.state),   32'(ma.st));
        check("a_flags", {29'b0, ia.running, ia.done, ia.overflow},
                         {29'b0, ma.st == 2'd1, ma.done, ma.ovf});
        check("b_bcd",   32'(ib.bcd_num), to_bcd(mb.val, 4));
        check("b_lap",   32'(ib.lap_num), to_bcd(mb.lap, 4));
        check("b_state", 32'(ib.state),   32'(mb.st));
        check("b_flags", {29'b0, ib.running, ib.done, ib.overflow},
                         {29'b0, mb.st == 2'd1, mb.done, mb.ovf});
    endtask

    task automatic drive(logic s, logic p, logic c, logic l);
        ia.start = s; ia.pause = p; ia.clear = c; ia.lap = l;
        ib.start = s; ib.pause = p; ib.clear = c; ib.lap = l;
        ia.count_down = cd; ib.count_down = cd;
        ia.preset = 8'(to_bcd(pre_a, 2));
        ib.preset = 16'(to_bcd(pre_b, 4));
    endtask

    task automatic cyc(logic s, logic p, logic c, logic l);
        drive(s, p, c, l);
        @(posedge clk);
        ma = m_next(ma, 4, 2, pre_a, s, p, c, l, cd);
        mb = m_next(mb, 2, 4, pre_b, s, p, c, l, cd);
        #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check_models();
    endtask

    task automatic run(int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        cd = 1'b0; pre_a = 0; pre_b = 0; n_rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        ma = '0; mb = '0;
        repeat (2) @(posedge clk);
        #1 check_models();
        @(negedge clk) n_rst = 1'b1;

        // up count, wrap and overflow on the 2-digit instance
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        run(4);
        check("up_first_step", 32'(ia.bcd_num), 32'h01);
        run(4 * 98);
        check("up_at_99", 32'(ia.bcd_num), 32'h99);
        check("no_ovf_yet", 32'(ia.overflow), 32'd0);
        run(4);
        check("up_wrap", 32'(ia.bcd_num), 32'h00);
        check("ovf_set", 32'(ia.overflow), 32'd1);
        check("run_after_wrap", 32'(ia.state), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("ovf_cleared", 32'(ia.overflow), 32'd0);

        // count-down on the 4-digit instance from 0010
        cd = 1'b1; pre_a = 10; pre_b = 10;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        run(2);
        check("down_first", 32'(ib.bcd_num), 32'h0009);
        run(2);
        check("down_second", 32'(ib.bcd_num), 32'h0008);
        run(16);
        check("down_zero", 32'(ib.bcd_num), 32'h0000);
        check("down_state", 32'(ib.state), 32'd3);
        check("done_pulse", 32'(ib.done), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("done_one_cycle", 32'(ib.done), 32'd0);
        check("done_ignores_start", 32'(ib.state), 32'd3);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("done_ignores_pause", 32'(ib.state), 32'd3);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cd = 1'b0;

        // pause with divider at 2 of 4, then resume
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        run(2);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        run(5);
        check("paused_hold", 32'(ia.bcd_num), 32'h00);
        check("paused_state", 32'(ia.state), 32'd2);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        run(1);
        check("resume_no_step", 32'(ia.bcd_num), 32'h00);
        run(1);
        check("resume_step", 32'(ia.bcd_num), 32'h01);

        // clear beats start; clear discards a coincident step
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        check("clear_start_state", 32'(ia.state), 32'd0);
        check("clear_start_bcd", 32'(ia.bcd_num), 32'h00);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        run(3);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("step_clear_state", 32'(ia.state), 32'd0);
        check("step_clear_bcd", 32'(ia.bcd_num), 32'h00);

        // down mode with zero preset goes straight to DONE
        cd = 1'b1; pre_a = 0; pre_b = 0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("zero_preset_state", 32'(ia.state), 32'd3);
        check("zero_preset_done", 32'(ia.done), 32'd1);
        run(1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cd = 1'b0;

        // lap in the same cycle as the 0x37 -> 0x38 step
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        run(4 * 37);
        check("lap_pre", 32'(ia.bcd_num), 32'h37);
        run(3);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("lap_bcd", 32'(ia.bcd_num), 32'h38);
        check("lap_num", 32'(ia.lap_num), LAP_ON ? 32'h37 : 32'h00);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);

        // random command mix, including coincident commands
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                cd    = 1'($urandom_range(0, 1));
                pre_a = int'($urandom_range(0, 12));
                pre_b = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15))
                                                    : int'($urandom_range(0, 9999));
            end
            cyc($urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
                $urandom_range(0, 49) == 0, $urandom_range(0, 5) == 0);
        end

        // asynchronous reset in RUN, without a clock edge
        cd = 1'b0;
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        run(5);
        #2 n_rst = 1'b0;
        #1;
        ma = '0; mb = '0;
        check_models();
        check("async_state", 32'(ia.state), 32'd0);
        check("async_bcd", 32'(ia.bcd_num), 32'h00);
        @(negedge clk) n_rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("restart_run", 32'(ia.state), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
